// File: rtl/alu_nop_unit.sv
// NOP execution slot of the 8-bit ALU: valid-only pipeline of LATENCY stages
// with ready/valid handshakes, constant-zero result and a saturating completion counter.

module alu_nop_stage (
   input  logic clk,
   input  logic rst,
   input  logic prev_vld_i,
   input  logic next_adv_i,
   output logic vld_o,
   output logic adv_o
);
   logic vld_q, vld_d;

   // A stage moves when it is empty or its successor is moving this cycle.
   assign adv_o = !vld_q || next_adv_i;
   assign vld_d = adv_o ? prev_vld_i : vld_q;
   assign vld_o = vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= vld_d;
   end
endmodule

module alu_nop_unit #(
   parameter int WIDTH     = 8,
   parameter int LATENCY   = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     opA,
   input  logic [WIDTH-1:0]     opB,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     result,
   output logic                 flag_z,
   output logic                 flag_c,
   output logic                 flag_v,
   output logic                 flag_n,
   output logic [CNT_WIDTH-1:0] nop_count
);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("alu_nop_unit: LATENCY must be within 1..4");
   end

   logic [LATENCY:0]   vld_pipe;
   logic [LATENCY+1:1] adv;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Operands carry no information for a NOP; they are deliberately sunk here.
   logic unused_ops;
   assign unused_ops = ^{opA, opB};

   assign vld_pipe[0]     = in_valid;
   assign adv[LATENCY+1]  = out_ready;

   for (genvar s = 1; s <= LATENCY; s++) begin : g_stage
      alu_nop_stage u_stage (
         .clk        (clk),
         .rst        (rst),
         .prev_vld_i (vld_pipe[s-1]),
         .next_adv_i (adv[s+1]),
         .vld_o      (vld_pipe[s]),
         .adv_o      (adv[s])
      );
   end

   assign in_ready  = adv[1];
   assign out_valid = vld_pipe[LATENCY];
   assign result    = '0;
   assign flag_z    = out_valid;
   assign flag_c    = 1'b0;
   assign flag_v    = 1'b0;
   assign flag_n    = 1'b0;
   assign nop_count = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready && !(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: tb/tb_alu_nop_unit.sv
// Bench for alu_nop_unit: token-position model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.

module tb_alu_nop_unit;
   localparam int L    = 3;
   localparam int CW   = 4;
   localparam int MAXC = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [7:0]    opA, opB, result;
   logic          flag_z, flag_c, flag_v, flag_n;
   logic [CW-1:0] nop_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   alu_nop_unit #(.WIDTH(8), .LATENCY(L), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opA(opA), .opB(opB), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .flag_n(flag_n), .nop_count(nop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: each in-flight NOP is a stage position 1..L; a token advances one
   // stage per cycle but never into the slot its predecessor still occupies.
   int mq[$];
   int mcnt = 0;
   int lim, np;
   bit fin;

   function automatic bit m_ov();
      if (mq.size() == 0) return 1'b0;
      return mq[0] == L;
   endfunction

   function automatic bit m_ir();
      return (mq.size() < L) || (m_ov() && out_ready);
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            mcnt = 0;
         end else begin
            fin = in_valid && m_ir();
            if (m_ov() && out_ready) begin
               void'(mq.pop_front());
               if (mcnt < MAXC) mcnt++;
            end
            lim = L;
            for (int i = 0; i < mq.size(); i++) begin
               np = mq[i] + 1;
               if (np > lim) np = lim;
               mq[i] = np;
               lim = np - 1;
            end
            if (fin) mq.push_back(1);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_out_valid", out_valid, m_ov());
         chk("cyc_in_ready", in_ready, m_ir());
         chk("cyc_result", result, 0);
         chk("cyc_flag_z", flag_z, m_ov());
         chk("cyc_flags_cvn", {flag_c, flag_v, flag_n}, 0);
         chk("cyc_nop_count", nop_count, mcnt);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   int n, nv, first, last, acc;
   logic [7:0] pat;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opA = '0; opB = '0;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {flag_z, flag_c, flag_v, flag_n}, 0);
      chk("rst_nop_count", nop_count, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      // Basic single NOP
      out_ready = 1'b1; opA = 8'd15; opB = 8'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0; opA = 8'hA5; opB = 8'h5A;
      n = 1;
      while (!out_valid && n < 20) begin step(); n++; end
      chk("basic_latency", n, L);
      chk("basic_result", result, 0);
      chk("basic_flag_z", flag_z, 1);
      chk("basic_flags_cvn", {flag_c, flag_v, flag_n}, 0);
      step();
      chk("basic_count", nop_count, 1);
      chk("basic_valid_gone", out_valid, 0);

      // Streaming 10 back-to-back
      do_reset(); out_ready = 1'b1;
      nv = 0; first = -1; last = -1;
      for (int c = 0; c < 20; c++) begin
         in_valid = (c < 10);
         opA = 8'(255 - 13 * c); opB = 8'(128 + 7 * c);
         if (out_valid) begin
            nv++;
            if (first < 0) first = c;
            last = c;
         end
         step();
      end
      chk("stream_valid_cycles", nv, 10);
      chk("stream_contiguous", last - first, 9);
      chk("stream_first_at_latency", first, L);
      chk("stream_count", nop_count, 10);

      // Backpressure with in_valid held
      do_reset(); out_ready = 1'b0; in_valid = 1'b1; acc = 0;
      for (int c = 0; c < 8; c++) begin
         if (in_ready) acc++;
         step();
      end
      chk("bp_accepts", acc, L);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_count", nop_count, 0);
      in_valid = 1'b0; out_ready = 1'b1; nv = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) nv++;
         step();
      end
      chk("bp_drained", nv, L);
      chk("bp_count_after", nop_count, L);

      // Irregular out_ready pattern under continuous input
      do_reset(); pat = 8'b1011_0010;
      for (int c = 0; c < 16; c++) begin
         in_valid = 1'b1;
         out_ready = pat[c % 8];
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) step();

      // Reset mid-flight
      do_reset(); out_ready = 1'b0; in_valid = 1'b1;
      step(); step();
      in_valid = 1'b0;
      step();
      chk("mid_pre_valid", out_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_out_valid", out_valid, 0);
      chk("mid_count", nop_count, 0);
      step();
      rst = 1'b0; out_ready = 1'b1;
      repeat (6) step();
      chk("mid_no_ghost", nop_count, 0);

      // Counter saturation
      do_reset(); out_ready = 1'b1; in_valid = 1'b1;
      repeat (20) step();
      in_valid = 1'b0;
      repeat (8) step();
      chk("sat_count", nop_count, 15);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
